// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifu_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_OUT  = 2'd3
   } fetch_state_t;

   // Instruction presented downstream whenever the fetch faulted (addi x0,x0,0).
   localparam logic [31:0] INST_NOP         = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one imem read per
// instruction, hands the result downstream and honours redirects at any time.
module ifu_fetch_ctrl
   import ifu_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exu_pc_valid,
   input  logic [31:0] exu_pc_next,
   input  logic        flush_valid,
   input  logic [31:0] flush_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic        out_fault,
   output logic        busy
);

   localparam int                CNT_W    = $clog2(TIMEOUT + 1);
   // The counter reads TIMEOUT-1 on the last WAIT cycle before faulting.
   localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);

   fetch_state_t     state_reg, state_next;
   logic [31:0]      pc_reg, pc_next;
   logic             drop_reg, drop_next;
   logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;
   logic [31:0]      out_inst_reg, out_inst_next;
   logic [31:0]      out_pc_reg, out_pc_next;
   logic             out_fault_reg, out_fault_next;

   logic             misaligned;
   assign misaligned = (pc_reg[1:0] != 2'b00);

   // State register: all architectural state advances together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_REQ;
         pc_reg        <= RESET_PC;
         drop_reg      <= 1'b0;
         tmo_cnt_reg   <= '0;
         out_inst_reg  <= '0;
         out_pc_reg    <= '0;
         out_fault_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         drop_reg      <= drop_next;
         tmo_cnt_reg   <= tmo_cnt_next;
         out_inst_reg  <= out_inst_next;
         out_pc_reg    <= out_pc_next;
         out_fault_reg <= out_fault_next;
      end
   end

   // Next-state logic; a flush overrides every other transition.
   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      drop_next      = drop_reg;
      tmo_cnt_next   = tmo_cnt_reg;
      out_inst_next  = out_inst_reg;
      out_pc_next    = out_pc_reg;
      out_fault_next = out_fault_reg;

      case (state_reg)
         ST_IDLE: begin
            if (exu_pc_valid) begin
               pc_next    = exu_pc_next;
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (misaligned) begin
               // No bus request for an unaligned PC; report it as a faulted fetch.
               out_inst_next  = INST_NOP;
               out_pc_next    = pc_reg;
               out_fault_next = 1'b1;
               state_next     = ST_OUT;
            end else if (imem_req_ready) begin
               tmo_cnt_next = '0;
               state_next   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            tmo_cnt_next = tmo_cnt_reg + CNT_W'(1);
            if (imem_rsp_valid) begin
               if (drop_reg) begin
                  // Response belongs to a fetch killed by an earlier flush.
                  drop_next  = 1'b0;
                  state_next = ST_REQ;
               end else begin
                  out_inst_next  = imem_rsp_err ? INST_NOP : imem_rsp_data;
                  out_pc_next    = pc_reg;
                  out_fault_next = imem_rsp_err;
                  state_next     = ST_OUT;
               end
            end else if (tmo_cnt_reg == TMO_LAST) begin
               out_inst_next  = INST_NOP;
               out_pc_next    = pc_reg;
               out_fault_next = 1'b1;
               drop_next      = 1'b0;
               state_next     = ST_OUT;
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_REQ;
      endcase

      if (flush_valid) begin
         pc_next = flush_pc;
         case (state_reg)
            ST_REQ: begin
               if (!misaligned && imem_req_ready) begin
                  // The old request was accepted this cycle; its response must be dropped.
                  tmo_cnt_next = '0;
                  drop_next    = 1'b1;
                  state_next   = ST_WAIT;
               end else begin
                  state_next = ST_REQ;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  drop_next  = 1'b0;
                  state_next = ST_REQ;
               end else begin
                  drop_next  = 1'b1;
                  state_next = ST_WAIT;
               end
            end
            default: begin
               // IDLE or OUT: a concurrent out_ready handshake does not count.
               state_next = ST_REQ;
            end
         endcase
      end
   end

   // Output decode from the current state.
   always_comb begin
      imem_req_valid = !rst && (state_reg == ST_REQ) && !misaligned;
      imem_req_addr  = pc_reg;
      out_valid      = (state_reg == ST_OUT);
      busy           = (state_reg != ST_IDLE);
      out_inst       = out_inst_reg;
      out_pc         = out_pc_reg;
      out_fault      = out_fault_reg;
   end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl with hand-computed expectations.
module tb_ifu_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        exu_pc_valid;
   logic [31:0] exu_pc_next;
   logic        flush_valid;
   logic [31:0] flush_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_fault;
   logic        busy;

   int n_asserts = 0;
   int n_fail    = 0;

   always #5 clk = ~clk;

   ifu_fetch_ctrl #(
      .RESET_PC(32'h8000_0000),
      .TIMEOUT (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .exu_pc_valid  (exu_pc_valid),
      .exu_pc_next   (exu_pc_next),
      .flush_valid   (flush_valid),
      .flush_pc      (flush_pc),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr (imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .imem_rsp_err  (imem_rsp_err),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_inst      (out_inst),
      .out_pc        (out_pc),
      .out_fault     (out_fault),
      .busy          (busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_asserts++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   // Advance one clock; outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From IDLE: load a PC from execute and land in REQ.
   task automatic start_fetch(input logic [31:0] pc);
      exu_pc_valid = 1'b1;
      exu_pc_next  = pc;
      tick();
      exu_pc_valid = 1'b0;
   endtask

   // From REQ (aligned): accept request, return a response, land in OUT.
   task automatic serve(input logic [31:0] data, input logic err);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      imem_rsp_err   = err;
      tick();
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
   endtask

   // From OUT: complete the downstream handshake, land in IDLE.
   task automatic ack();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      exu_pc_valid   = 1'b0;
      exu_pc_next    = '0;
      flush_valid    = 1'b0;
      flush_pc       = '0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      out_ready      = 1'b0;
      tick();
      tick();
      check_eq("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check_eq("rst_out_inst", out_inst, 32'h0);
      check_eq("rst_out_pc", out_pc, 32'h0);
      check_eq("rst_out_fault", {31'b0, out_fault}, 32'd0);

      // Basic fetch after reset.
      rst = 1'b0;
      #1;
      check_eq("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check_eq("first_req_addr", imem_req_addr, 32'h8000_0000);
      serve(32'h0010_0093, 1'b0);
      check_eq("first_out_valid", {31'b0, out_valid}, 32'd1);
      check_eq("first_out_inst", out_inst, 32'h0010_0093);
      check_eq("first_out_pc", out_pc, 32'h8000_0000);
      check_eq("first_out_fault", {31'b0, out_fault}, 32'd0);

      // Backpressure: outputs hold while out_ready is low.
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq($sformatf("hold%0d_valid", i), {31'b0, out_valid}, 32'd1);
         check_eq($sformatf("hold%0d_inst", i), out_inst, 32'h0010_0093);
         check_eq($sformatf("hold%0d_pc", i), out_pc, 32'h8000_0000);
      end
      ack();
      check_eq("idle_busy", {31'b0, busy}, 32'd0);
      check_eq("idle_out_valid", {31'b0, out_valid}, 32'd0);

      // Sequential PC from execute.
      start_fetch(32'h8000_0004);
      check_eq("seq_req_addr", imem_req_addr, 32'h8000_0004);
      check_eq("seq_req_valid", {31'b0, imem_req_valid}, 32'd1);
      serve(32'h1234_5678, 1'b0);
      check_eq("seq_out_inst", out_inst, 32'h1234_5678);
      check_eq("seq_out_pc", out_pc, 32'h8000_0004);
      ack();

      // Misaligned PC: no bus request, faulted NOP.
      start_fetch(32'h8000_0006);
      check_eq("mis_req_valid", {31'b0, imem_req_valid}, 32'd0);
      tick();
      check_eq("mis_out_valid", {31'b0, out_valid}, 32'd1);
      check_eq("mis_out_fault", {31'b0, out_fault}, 32'd1);
      check_eq("mis_out_inst", out_inst, 32'h0000_0013);
      check_eq("mis_out_pc", out_pc, 32'h8000_0006);
      ack();

      // Flush in WAIT; the stale response must be discarded.
      start_fetch(32'h8000_0008);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      flush_valid = 1'b1;
      flush_pc    = 32'h8000_0100;
      tick();
      flush_valid = 1'b0;
      check_eq("flw_req_valid", {31'b0, imem_req_valid}, 32'd0);
      tick();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hAAAA_AAAA;
      tick();
      imem_rsp_valid = 1'b0;
      check_eq("flw_out_valid", {31'b0, out_valid}, 32'd0);
      check_eq("flw_out_inst", out_inst, 32'h0000_0013);
      check_eq("flw_req_valid2", {31'b0, imem_req_valid}, 32'd1);
      check_eq("flw_req_addr", imem_req_addr, 32'h8000_0100);
      serve(32'h0000_0513, 1'b0);
      check_eq("flw_new_inst", out_inst, 32'h0000_0513);
      check_eq("flw_new_pc", out_pc, 32'h8000_0100);
      ack();

      // Timeout after 8 WAIT cycles; a late response is ignored.
      start_fetch(32'h8000_0200);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         check_eq($sformatf("tmo_wait%0d", i), {31'b0, out_valid}, 32'd0);
      end
      tick();
      check_eq("tmo_out_valid", {31'b0, out_valid}, 32'd1);
      check_eq("tmo_out_fault", {31'b0, out_fault}, 32'd1);
      check_eq("tmo_out_inst", out_inst, 32'h0000_0013);
      check_eq("tmo_out_pc", out_pc, 32'h8000_0200);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBBBB_BBBB;
      tick();
      imem_rsp_valid = 1'b0;
      check_eq("tmo_late_inst", out_inst, 32'h0000_0013);
      check_eq("tmo_late_fault", {31'b0, out_fault}, 32'd1);
      ack();

      // Bus error response.
      start_fetch(32'h8000_0300);
      serve(32'hDEAD_BEEF, 1'b1);
      check_eq("err_out_fault", {31'b0, out_fault}, 32'd1);
      check_eq("err_out_inst", out_inst, 32'h0000_0013);
      check_eq("err_out_pc", out_pc, 32'h8000_0300);
      ack();

      // Reset while in WAIT; a late response after reset is ignored.
      start_fetch(32'h8000_0400);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      rst = 1'b1;
      tick();
      check_eq("wrst_out_valid", {31'b0, out_valid}, 32'd0);
      check_eq("wrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      rst = 1'b0;
      #1;
      check_eq("wrst_req_valid2", {31'b0, imem_req_valid}, 32'd1);
      check_eq("wrst_req_addr", imem_req_addr, 32'h8000_0000);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hCCCC_CCCC;
      tick();
      imem_rsp_valid = 1'b0;
      check_eq("wrst_late_out_valid", {31'b0, out_valid}, 32'd0);
      check_eq("wrst_late_req_valid", {31'b0, imem_req_valid}, 32'd1);

      // Flush in OUT wins over a concurrent out_ready.
      serve(32'h0000_0001, 1'b0);
      check_eq("flo_out_valid", {31'b0, out_valid}, 32'd1);
      flush_valid = 1'b1;
      flush_pc    = 32'h8000_0500;
      out_ready   = 1'b1;
      tick();
      flush_valid = 1'b0;
      out_ready   = 1'b0;
      check_eq("flo_out_valid2", {31'b0, out_valid}, 32'd0);
      check_eq("flo_busy", {31'b0, busy}, 32'd1);
      check_eq("flo_req_addr", imem_req_addr, 32'h8000_0500);
      serve(32'h0000_0002, 1'b0);
      ack();

      // Flush and execute PC together in IDLE: flush wins.
      exu_pc_valid = 1'b1;
      exu_pc_next  = 32'h8000_0600;
      flush_valid  = 1'b1;
      flush_pc     = 32'h8000_0700;
      tick();
      exu_pc_valid = 1'b0;
      flush_valid  = 1'b0;
      check_eq("prio_req_addr", imem_req_addr, 32'h8000_0700);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
